// File: rtl/com_uart_pkg.sv
// Shared definitions for the com_uart TX/RX paths: baud codes, TX state
// encoding and the baud-code to divide-shift mapping.
package com_uart_pkg;

    localparam int BD4800_ENCODE  = 0;
    localparam int BD9600_ENCODE  = 1;
    localparam int BD19200_ENCODE = 2;
    localparam int BD38400_ENCODE = 3;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    // Right-shift applied to the 4800-baud divider; unknown codes run at 38400.
    function automatic logic [1:0] baud_shift(
        input logic [1:0] sel,
        input logic [1:0] enc_4800,
        input logic [1:0] enc_9600,
        input logic [1:0] enc_19200,
        input logic [1:0] enc_38400
    );
        if (sel == enc_38400)      return 2'd3;
        else if (sel == enc_4800)  return 2'd0;
        else if (sel == enc_9600)  return 2'd1;
        else if (sel == enc_19200) return 2'd2;
        else                       return 2'd3;
    endfunction

endpackage

// File: rtl/com_uart_tx_baud_gen.sv
// Bit-period timer for the UART transmitter: one-cycle bit_tick every
// (bit_last + 1) clocks while enabled, cleared whenever disabled.
module com_uart_tx_baud_gen #(
    parameter int CW = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [CW-1:0] bit_last,
    output logic          bit_tick
);

    logic [CW-1:0] cnt;

    assign bit_tick = enable && (cnt == bit_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/com_uart_transmitter.sv
// UART transmitter: start bit, LSB-first data, optional even parity and
// 1 or 2 stop bits, with per-frame baud selection latched at accept.
module com_uart_transmitter #(
    parameter int CLK_DIV_BD4800 = 26042,
    parameter int BD4800_ENCODE  = com_uart_pkg::BD4800_ENCODE,
    parameter int BD9600_ENCODE  = com_uart_pkg::BD9600_ENCODE,
    parameter int BD19200_ENCODE = com_uart_pkg::BD19200_ENCODE,
    parameter int BD38400_ENCODE = com_uart_pkg::BD38400_ENCODE,
    parameter int DATA_WIDTH     = 8,
    parameter int PARITY_EN      = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            baudrate_sel,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_port,
    output logic                  tx_busy,
    output logic                  tx_done
);

    import com_uart_pkg::*;

    localparam int CW = $clog2(CLK_DIV_BD4800);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
    localparam logic LAST_STOP = (STOP_BITS > 1);

    tx_state_t             state, state_next;
    logic [DATA_WIDTH-1:0] shift_q, shift_next;
    logic [IW-1:0]         idx_q, idx_next;
    logic                  stop_q, stop_next;
    logic                  parity_q, parity_next;
    logic [CW-1:0]         bit_last_q, bit_last_next, bit_last_sel;
    logic                  port_q, port_next;
    logic                  ready_q, ready_next;
    logic                  done_q, done_next;
    logic                  bit_tick;
    logic [1:0]            div_shift;

    assign div_shift = baud_shift(baudrate_sel, 2'(BD4800_ENCODE), 2'(BD9600_ENCODE),
                                  2'(BD19200_ENCODE), 2'(BD38400_ENCODE));
    assign bit_last_sel = CW'((CLK_DIV_BD4800 >> div_shift) - 1);

    assign tx_ready = ready_q;
    assign tx_port  = port_q;
    assign tx_done  = done_q;
    assign tx_busy  = (state != TX_IDLE);

    com_uart_tx_baud_gen #(.CW(CW)) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (tx_busy),
        .bit_last (bit_last_q),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_next    = state;
        shift_next    = shift_q;
        idx_next      = idx_q;
        stop_next     = stop_q;
        parity_next   = parity_q;
        bit_last_next = bit_last_q;
        done_next     = 1'b0;

        case (state)
            TX_IDLE: begin
                if (tx_valid && ready_q) begin
                    state_next    = TX_START;
                    shift_next    = tx_data;
                    parity_next   = ^tx_data;
                    bit_last_next = bit_last_sel;
                    idx_next      = '0;
                    stop_next     = 1'b0;
                end
            end
            TX_START: begin
                if (bit_tick) state_next = TX_DATA;
            end
            TX_DATA: begin
                if (bit_tick) begin
                    if (idx_q == LAST_IDX) begin
                        state_next = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
                    end else begin
                        idx_next   = idx_q + 1'b1;
                        shift_next = shift_q >> 1;
                    end
                end
            end
            TX_PARITY: begin
                if (bit_tick) state_next = TX_STOP;
            end
            TX_STOP: begin
                if (bit_tick) begin
                    if (stop_q == LAST_STOP) begin
                        state_next = TX_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        stop_next = 1'b1;
                    end
                end
            end
            default: state_next = TX_IDLE;
        endcase

        // Line level is registered from the next state so the pin never glitches.
        case (state_next)
            TX_START:  port_next = 1'b0;
            TX_DATA:   port_next = shift_next[0];
            TX_PARITY: port_next = parity_next;
            default:   port_next = 1'b1;
        endcase
        ready_next = (state_next == TX_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= TX_IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            stop_q     <= 1'b0;
            parity_q   <= 1'b0;
            bit_last_q <= '0;
            port_q     <= 1'b1;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state      <= state_next;
            shift_q    <= shift_next;
            idx_q      <= idx_next;
            stop_q     <= stop_next;
            parity_q   <= parity_next;
            bit_last_q <= bit_last_next;
            port_q     <= port_next;
            ready_q    <= ready_next;
            done_q     <= done_next;
        end
    end

endmodule

// File: tb/tb_com_uart_transmitter.sv
// Directed plus randomized frames on two transmitter configurations, checked
// cycle by cycle against an expected bit queue built from the frame format.
module tb_com_uart_transmitter;

    localparam int CLK_DIV = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] baudrate_sel = 2'd0;
    logic [7:0] tx_data = 8'h00;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic       ready_a, port_a, busy_a, done_a;
    logic       ready_b, port_b, busy_b, done_b;

    int         dut_sel = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [0:0] exp_q[$];
    int         bc_tab[4] = '{64, 32, 16, 8};

    always #5 clk = ~clk;

    com_uart_transmitter #(.CLK_DIV_BD4800(CLK_DIV)) dut_a (
        .clk(clk), .rst_n(rst_n), .baudrate_sel(baudrate_sel), .tx_data(tx_data),
        .tx_valid(valid_a), .tx_ready(ready_a), .tx_port(port_a),
        .tx_busy(busy_a), .tx_done(done_a)
    );

    com_uart_transmitter #(.CLK_DIV_BD4800(CLK_DIV), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .baudrate_sel(baudrate_sel), .tx_data(tx_data),
        .tx_valid(valid_b), .tx_ready(ready_b), .tx_port(port_b),
        .tx_busy(busy_b), .tx_done(done_b)
    );

    function automatic logic cur_port();  return (dut_sel == 0) ? port_a  : port_b;  endfunction
    function automatic logic cur_ready(); return (dut_sel == 0) ? ready_a : ready_b; endfunction
    function automatic logic cur_busy();  return (dut_sel == 0) ? busy_a  : busy_b;  endfunction
    function automatic logic cur_done();  return (dut_sel == 0) ? done_a  : done_b;  endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_valid(input logic v);
        if (dut_sel == 0) valid_a = v;
        else              valid_b = v;
    endtask

    // Called at a negedge; returns at the negedge of the first frame cycle.
    task automatic accept(input logic [7:0] data);
        check("ready_before_accept", 16'(cur_ready()), 16'd1);
        tx_data = data;
        set_valid(1'b1);
        @(negedge clk);
        set_valid(1'b0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            check("idle_port",  16'(cur_port()),  16'd1);
            check("idle_ready", 16'(cur_ready()), 16'd1);
            check("idle_busy",  16'(cur_busy()),  16'd0);
            check("idle_done",  16'(cur_done()),  16'd0);
            @(negedge clk);
        end
    endtask

    // Checks every cycle of a frame, then the tx_done cycle (without advancing).
    task automatic check_frame(input logic [7:0] data, input int bc, input bit par,
                               input int stops, input int abort_at, input bit disturb);
        int   cyc;
        logic b;
        exp_q = {};
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(data[i]);
        if (par) exp_q.push_back(^data);
        for (int s = 0; s < stops; s++) exp_q.push_back(1'b1);
        cyc = 0;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            for (int c = 0; c < bc; c++) begin
                if (cyc == abort_at) return;
                check("frame_port",  16'(cur_port()),  16'(b));
                check("frame_busy",  16'(cur_busy()),  16'd1);
                check("frame_ready", 16'(cur_ready()), 16'd0);
                check("frame_done",  16'(cur_done()),  16'd0);
                if (disturb && cyc == 100) begin
                    baudrate_sel = 2'd3;
                    tx_data = 8'h55;
                    set_valid(1'b1);
                end
                if (disturb && cyc == 110) set_valid(1'b0);
                @(negedge clk);
                cyc++;
            end
        end
        check("done_pulse", 16'(cur_done()),  16'd1);
        check("done_ready", 16'(cur_ready()), 16'd1);
        check("done_port",  16'(cur_port()),  16'd1);
        check("done_busy",  16'(cur_busy()),  16'd0);
    endtask

    initial begin
        int s, g;
        logic [7:0] d;

        // Reset state on both configurations
        repeat (3) @(negedge clk);
        check("rst_port_a",  16'(port_a),  16'd1);
        check("rst_ready_a", 16'(ready_a), 16'd1);
        check("rst_busy_a",  16'(busy_a),  16'd0);
        check("rst_port_b",  16'(port_b),  16'd1);
        check("rst_ready_b", 16'(ready_b), 16'd1);
        rst_n = 1'b1;
        @(negedge clk);
        idle_cycles(100);

        // 0xA5 at 4800 code: 64-cycle bits, done at cycle 641
        baudrate_sel = 2'd0;
        accept(8'hA5);
        check_frame(8'hA5, bc_tab[0], 1'b0, 1, -1, 1'b0);
        @(negedge clk);
        idle_cycles(5);

        // Back-to-back 0x00 then 0xFF at 38400 code
        baudrate_sel = 2'd3;
        accept(8'h00);
        check_frame(8'h00, bc_tab[3], 1'b0, 1, -1, 1'b0);
        accept(8'hFF);
        check_frame(8'hFF, bc_tab[3], 1'b0, 1, -1, 1'b0);
        @(negedge clk);
        idle_cycles(5);

        // Parity + two stop bits at 9600 code
        dut_sel = 1;
        baudrate_sel = 2'd1;
        accept(8'h07);
        check_frame(8'h07, bc_tab[1], 1'b1, 2, -1, 1'b0);
        @(negedge clk);
        idle_cycles(5);
        dut_sel = 0;

        // Baud change and extra tx_valid mid-frame are ignored
        baudrate_sel = 2'd0;
        accept(8'h96);
        check_frame(8'h96, bc_tab[0], 1'b0, 1, -1, 1'b1);
        @(negedge clk);
        idle_cycles(700);

        // Reset during data bit 4, then a clean 0x3C frame
        baudrate_sel = 2'd0;
        accept(8'hC3);
        check_frame(8'hC3, bc_tab[0], 1'b0, 1, 5 * CLK_DIV + 10, 1'b0);
        rst_n = 1'b0;
        #1;
        check("reset_port_now", 16'(port_a),  16'd1);
        check("reset_busy_now", 16'(busy_a),  16'd0);
        check("reset_ready_now", 16'(ready_a), 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle_cycles(3);
        accept(8'h3C);
        check_frame(8'h3C, bc_tab[0], 1'b0, 1, -1, 1'b0);
        @(negedge clk);
        idle_cycles(2);

        // Randomized frames, gaps and post-accept baud changes
        for (int k = 0; k < 8; k++) begin
            dut_sel = (k >= 6) ? 1 : 0;
            d = 8'($urandom_range(0, 255));
            s = $urandom_range(0, 3);
            g = $urandom_range(0, 2);
            baudrate_sel = 2'(s);
            accept(d);
            baudrate_sel = 2'($urandom_range(0, 3));
            check_frame(d, bc_tab[s], dut_sel == 1, (dut_sel == 1) ? 2 : 1, -1, 1'b0);
            if (g > 0 || k == 5 || k == 7) begin
                @(negedge clk);
                idle_cycles(g);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
